// File: rtl/rv_uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer and first-word fall-through byte storage.
// Define RV_UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
`timescale 1ns/1ps

module rv_uart_rx #(
  parameter int unsigned DIV        = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       xreset,
  input  logic       rxd,
  input  logic       rd,
  input  logic       err_clr,
  output logic [7:0] rdata,
  output logic       rx_avail,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] CntBit  = 16'(DIV - 1);
  localparam logic [15:0] CntHalf = 16'(DIV / 2 - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [1:0]  r_sync;
  logic        r_rxs_prev;
  logic        w_rxs;

  logic [1:0]  r_state, w_state_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic [2:0]  r_idx, w_idx_d;
  logic [7:0]  r_shift, w_shift_d;

  logic        w_push;
  logic        w_stop_bad;
  logic        w_pop;
  logic        w_wr;
  logic        w_ovf;

  logic        r_frame_err, w_frame_err_d;
  logic        r_overrun, w_overrun_d;

  assign w_rxs = r_sync[1];

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_sync     <= 2'b11;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[0], rxd};
      r_rxs_prev <= w_rxs;
    end
  end

  // Falling-edge detect on the synchronized line means a low stop bit must go high
  // again before the next start can be recognized.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_idx_d    = r_idx;
    w_shift_d  = r_shift;
    w_push     = 1'b0;
    w_stop_bad = 1'b0;
    case (r_state)
      StIdle: begin
        if (r_rxs_prev && !w_rxs) begin
          w_state_d = StStart;
          w_cnt_d   = CntHalf;
        end
      end
      StStart: begin
        if (r_cnt == 16'd0) begin
          if (w_rxs) begin
            w_state_d = StIdle;
          end else begin
            w_state_d = StData;
            w_cnt_d   = CntBit;
            w_idx_d   = 3'd0;
          end
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      StData: begin
        if (r_cnt == 16'd0) begin
          w_shift_d[r_idx] = w_rxs;
          w_cnt_d          = CntBit;
          w_idx_d          = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_d = StStop;
          end
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      StStop: begin
        if (r_cnt == 16'd0) begin
          w_state_d  = StIdle;
          w_push     = w_rxs;
          w_stop_bad = !w_rxs;
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_state <= StIdle;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_idx   <= w_idx_d;
      r_shift <= w_shift_d;
    end
  end

`ifdef RV_UART_RX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_empty;
  logic        w_full;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A same-cycle pop frees the slot the push lands in, so a full FIFO still accepts.
  assign w_pop = rd && !w_empty;
  assign w_wr  = w_push && (!w_full || w_pop);
  assign w_ovf = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= r_shift;
    end
  end

  assign rdata    = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
  assign rx_avail = !w_empty;
  assign rx_full  = w_full;
`else
  logic [7:0] r_hold;
  logic       r_valid;
  logic       w_unused_depth;

  assign w_unused_depth = ^FIFO_DEPTH;

  assign w_pop = rd && r_valid;
  assign w_wr  = w_push && (!r_valid || w_pop);
  assign w_ovf = w_push && r_valid && !w_pop;

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_hold  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      if (w_wr) begin
        r_hold  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rdata    = r_valid ? r_hold : 8'h00;
  assign rx_avail = r_valid;
  assign rx_full  = r_valid;
`endif

  // Setting events take priority over err_clr in the same cycle.
  always_comb begin
    w_frame_err_d = r_frame_err;
    w_overrun_d   = r_overrun;
    if (err_clr) begin
      w_frame_err_d = 1'b0;
      w_overrun_d   = 1'b0;
    end
    if (w_stop_bad) begin
      w_frame_err_d = 1'b1;
    end
    if (w_ovf) begin
      w_overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err_d;
      r_overrun   <= w_overrun_d;
    end
  end

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_rv_uart_rx.sv
// Scoreboard bench for rv_uart_rx: bytes expected in storage are queued as frames are sent
// and compared as they are popped; status outputs are checked against the model after every frame.
`timescale 1ns/1ps

module tb_rv_uart_rx;

  localparam int unsigned DIV        = 16;
  localparam int unsigned FIFO_DEPTH = 4;
`ifdef RV_UART_RX_FIFO_EN
  localparam int unsigned DEPTH = FIFO_DEPTH;
`else
  localparam int unsigned DEPTH = 1;
`endif
  // Negedges into the stop bit after which the next rising edge is the stop sample edge:
  // 2 sync flops + edge detect + DIV/2 start count, then 8*DIV data, then DIV-1 into stop.
  localparam int STOP_POP = 10;

  logic       clk = 1'b0;
  logic       xreset;
  logic       rxd;
  logic       rd;
  logic       err_clr;
  logic [7:0] rdata;
  logic       rx_avail;
  logic       rx_full;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic       m_frame_err = 1'b0;
  logic       m_overrun   = 1'b0;

  rv_uart_rx #(
    .DIV       (DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .xreset   (xreset),
    .rxd      (rxd),
    .rd       (rd),
    .err_clr  (err_clr),
    .rdata    (rdata),
    .rx_avail (rx_avail),
    .rx_full  (rx_full),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check_val({tag, " rx_avail"}, {31'd0, rx_avail}, {31'd0, exp_q.size() != 0});
    check_val({tag, " rx_full"}, {31'd0, rx_full}, {31'd0, exp_q.size() == DEPTH});
    check_val({tag, " frame_err"}, {31'd0, frame_err}, {31'd0, m_frame_err});
    check_val({tag, " overrun"}, {31'd0, overrun}, {31'd0, m_overrun});
    if (exp_q.size() != 0) begin
      check_val({tag, " rdata"}, {24'd0, rdata}, {24'd0, exp_q[0]});
    end
  endtask

  // Called and returns on a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input logic stop, input logic pop_at_stop);
    logic [7:0] head;
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    for (int i = 0; i < DIV; i++) begin
      if (i == STOP_POP) begin
        check_val("pre-stop rx_avail", {31'd0, rx_avail}, {31'd0, exp_q.size() != 0});
        if (pop_at_stop) begin
          head = exp_q.pop_front();
          check_val("stop-cycle pop rdata", {24'd0, rdata}, {24'd0, head});
          rd = 1'b1;
        end
      end
      if (i == STOP_POP + 1) begin
        rd = 1'b0;
        if (stop) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(b);
          else m_overrun = 1'b1;
        end else begin
          m_frame_err = 1'b1;
        end
        check_status("post-stop");
      end
      @(negedge clk);
    end
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_byte(input string tag);
    logic [7:0] head;
    check_val({tag, " pre-pop rx_avail"}, {31'd0, rx_avail}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      head = exp_q.pop_front();
      check_val({tag, " pop rdata"}, {24'd0, rdata}, {24'd0, head});
    end
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check_status(tag);
  endtask

  task automatic clear_errors(input string tag);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr     = 1'b0;
    m_frame_err = 1'b0;
    m_overrun   = 1'b0;
    check_status(tag);
  endtask

  initial begin
    xreset  = 1'b0;
    rxd     = 1'b1;
    rd      = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_status("reset");
    check_val("reset rdata", {24'd0, rdata}, 32'd0);
    xreset = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte, then pop; then a pop request on empty storage is ignored.
    send_byte(8'h55, 1'b1, 1'b0);
    pop_byte("pop 55");
    pop_byte("empty rd");

    // Fill past capacity without popping.
    for (int i = 0; i < 5; i++) send_byte(8'h41 + 8'(i), 1'b1, 1'b0);
    repeat (DEPTH) pop_byte("drain fill");
    clear_errors("clr overrun");

    // Low stop bit, then clear.
    send_byte(8'hA5, 1'b0, 1'b0);
    clear_errors("clr frame_err");

    // A flag set in the same cycle as err_clr reads 1.
    err_clr = 1'b1;
    send_byte(8'h3A, 1'b0, 1'b0);
    err_clr     = 1'b0;
    m_frame_err = 1'b0;
    check_status("set beats clr");

    // Short low glitch must not start a frame.
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check_status("glitch");
    send_byte(8'hC3, 1'b1, 1'b0);
    pop_byte("pop after glitch");

    // Full storage, pop during the stop-sample cycle of the next byte.
    for (int i = 0; i < DEPTH; i++) send_byte(8'h41 + 8'(i), 1'b1, 1'b0);
    send_byte(8'h99, 1'b1, 1'b1);
    repeat (DEPTH) pop_byte("drain push-pop");
    check_val("last out drained", {31'd0, rx_avail}, 32'd0);

    // Reset during bit 3 of 0x3C abandons it.
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = (8'h3C >> i) & 8'h01;
      repeat (DIV) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (DIV / 2) @(negedge clk);
    xreset = 1'b0;
    exp_q.delete();
    m_frame_err = 1'b0;
    m_overrun   = 1'b0;
    repeat (3) @(negedge clk);
    check_status("mid-frame reset");
    xreset = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check_status("after reset release");
    send_byte(8'h7E, 1'b1, 1'b0);
    pop_byte("pop 7E");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
